seq_mult8_ctrl: RTL and testbench

- Sequential shift-and-add controller for unsigned 8x8 -> 16-bit multiply.
- Time-shares one instance of the team's 8-bit ripple-carry adder (FullAdder_8), with cin tied to 0, across 8 iterations.
- Sits between a requester (start/done handshake) and the shared adder. One product per request; no pipelining.

---
 rtl/seq_mult8_ctrl.sv | 153 +++++++++++++++
 tb/tb_seq_mult8_ctrl.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/seq_mult8_ctrl.sv
// Sequential shift-and-add unsigned 8x8 -> 16-bit multiplier controller.
// One shared 8-bit ripple-carry adder is reused across eight ADD/SHIFT iterations.

module FullAdder_8 (
  input  logic [7:0] a,
  input  logic [7:0] b,
  input  logic       cin,
  output logic [7:0] sum,
  output logic       cout
);

  logic [8:0] carry_s;

  assign carry_s[0] = cin;

  for (genvar i = 0; i < 8; i++) begin : g_bit
    assign sum[i]       = a[i] ^ b[i] ^ carry_s[i];
    assign carry_s[i+1] = (a[i] & b[i]) | (carry_s[i] & (a[i] ^ b[i]));
  end

  assign cout = carry_s[8];

endmodule

module seq_mult8_ctrl (
  input  logic        clk,
  input  logic        rstn,
  input  logic        start,
  input  logic [7:0]  a,
  input  logic [7:0]  b,
  output logic        busy,
  output logic        done,
  output logic [15:0] product
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ADD   = 2'd1,
    ST_SHIFT = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  state_t      state_q, state_d;
  logic [7:0]  m_q, m_d;
  logic [7:0]  a_q, a_d;
  logic [7:0]  q_q, q_d;
  logic        c_q, c_d;
  logic [2:0]  cnt_q, cnt_d;
  logic [15:0] product_q, product_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;

  logic [7:0]  add_sum_s;
  logic        add_cout_s;
  logic [7:0]  shift_a_s;
  logic [7:0]  shift_q_s;

  FullAdder_8 u_adder (
    .a    (a_q),
    .b    (m_q),
    .cin  (1'b0),
    .sum  (add_sum_s),
    .cout (add_cout_s)
  );

  // The carry becomes the accumulator MSB so high-order product bits survive.
  assign shift_a_s = {c_q, a_q[7:1]};
  assign shift_q_s = {a_q[0], q_q[7:1]};

  // Next-state and datapath update.
  always_comb begin
    state_d   = state_q;
    m_d       = m_q;
    a_d       = a_q;
    q_d       = q_q;
    c_d       = c_q;
    cnt_d     = cnt_q;
    product_d = product_q;

    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          m_d     = a;
          q_d     = b;
          a_d     = 8'h00;
          c_d     = 1'b0;
          cnt_d   = 3'd0;
          state_d = ST_ADD;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_ADD: begin
        if (q_q[0]) begin
          a_d = add_sum_s;
          c_d = add_cout_s;
        end else begin
          a_d = a_q;
          c_d = 1'b0;
        end
        state_d = ST_SHIFT;
      end
      ST_SHIFT: begin
        a_d = shift_a_s;
        q_d = shift_q_s;
        c_d = 1'b0;
        if (cnt_q == 3'd7) begin
          product_d = {shift_a_s, shift_q_s};
          state_d   = ST_DONE;
        end else begin
          cnt_d   = cnt_q + 3'd1;
          state_d = ST_ADD;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    busy_d = (state_d == ST_ADD) || (state_d == ST_SHIFT);
    done_d = (state_d == ST_DONE);
  end

  // State and datapath registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q   <= ST_IDLE;
      m_q       <= 8'h00;
      a_q       <= 8'h00;
      q_q       <= 8'h00;
      c_q       <= 1'b0;
      cnt_q     <= 3'd0;
      product_q <= 16'h0000;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      m_q       <= m_d;
      a_q       <= a_d;
      q_q       <= q_d;
      c_q       <= c_d;
      cnt_q     <= cnt_d;
      product_q <= product_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  assign busy    = busy_q;
  assign done    = done_q;
  assign product = product_q;

endmodule

// File: tb/tb_seq_mult8_ctrl.sv
// Self-checking bench for seq_mult8_ctrl: directed corner cases plus random
// operands compared against plain integer multiplication.

module tb_seq_mult8_ctrl;

  logic        clk;
  logic        rstn;
  logic        start;
  logic [7:0]  a;
  logic [7:0]  b;
  logic        busy;
  logic        done;
  logic [15:0] product;

  int          checks;
  int          errors;
  logic [15:0] model_prod;

  seq_mult8_ctrl dut (
    .clk     (clk),
    .rstn    (rstn),
    .start   (start),
    .a       (a),
    .b       (b),
    .busy    (busy),
    .done    (done),
    .product (product)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One full operation from IDLE: 16 busy cycles, a single done cycle, then IDLE.
  task automatic mult_op(input logic [7:0] op_a, input logic [7:0] op_b, input string tag);
    logic [15:0] prev;
    prev  = model_prod;
    start = 1'b1;
    a     = op_a;
    b     = op_b;
    step();
    start = 1'b0;
    a     = 8'($urandom);
    b     = 8'($urandom);
    for (int c = 1; c <= 16; c++) begin
      if (c > 1) step();
      checks++;
      if (busy !== 1'b1 || done !== 1'b0 || product !== prev) begin
        errors++;
        $display("FAIL %s busy_phase cyc=%0d: busy=%b done=%b product=%h, required busy=1 done=0 product=%h",
                 tag, c, busy, done, product, prev);
      end
    end
    step();
    model_prod = {8'h00, op_a} * {8'h00, op_b};
    checks++;
    if (done !== 1'b1 || busy !== 1'b0 || product !== model_prod) begin
      errors++;
      $display("FAIL %s done_cycle a=%h b=%h: done=%b busy=%b product=%h, required done=1 busy=0 product=%h",
               tag, op_a, op_b, done, busy, product, model_prod);
    end
    step();
    checks++;
    if (done !== 1'b0 || busy !== 1'b0 || product !== model_prod) begin
      errors++;
      $display("FAIL %s after_done: done=%b busy=%b product=%h, required done=0 busy=0 product=%h",
               tag, done, busy, product, model_prod);
    end
  endtask

  task automatic test_reset();
    rstn  = 1'b0;
    start = 1'b0;
    a     = 8'h00;
    b     = 8'h00;
    model_prod = 16'h0000;
    step();
    step();
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || product !== 16'h0000) begin
      errors++;
      $display("FAIL reset_state: busy=%b done=%b product=%h, required 0 0 0000", busy, done, product);
    end
    rstn = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      checks++;
      if (busy !== 1'b0 || done !== 1'b0 || product !== 16'h0000) begin
        errors++;
        $display("FAIL reset_idle cyc=%0d: busy=%b done=%b product=%h, required 0 0 0000",
                 i, busy, done, product);
      end
    end
  endtask

  task automatic test_basic();
    mult_op(8'h0F, 8'h11, "basic");
    checks++;
    if (product !== 16'h00FF) begin
      errors++;
      $display("FAIL basic_value: product=%h, required 00ff", product);
    end
    for (int i = 0; i < 10; i++) begin
      step();
      checks++;
      if (product !== 16'h00FF || done !== 1'b0 || busy !== 1'b0) begin
        errors++;
        $display("FAIL basic_hold cyc=%0d: product=%h done=%b busy=%b, required 00ff 0 0",
                 i, product, done, busy);
      end
    end
  endtask

  task automatic test_corners();
    mult_op(8'hFF, 8'hFF, "max");
    checks++;
    if (product !== 16'hFE01) begin
      errors++;
      $display("FAIL max_value: product=%h, required fe01", product);
    end
    mult_op(8'h00, 8'hA5, "zero");
    checks++;
    if (product !== 16'h0000) begin
      errors++;
      $display("FAIL zero_value: product=%h, required 0000", product);
    end
    mult_op(8'h80, 8'h02, "msb");
    checks++;
    if (product !== 16'h0100) begin
      errors++;
      $display("FAIL msb_value: product=%h, required 0100", product);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 24; i++) begin
      mult_op(8'($urandom), 8'($urandom), "random");
      for (int j = 0; j < int'($urandom_range(0, 3)); j++) step();
    end
  endtask

  task automatic test_ignore_busy_start();
    start = 1'b1;
    a     = 8'h03;
    b     = 8'h04;
    step();
    start = 1'b0;
    for (int c = 1; c <= 16; c++) begin
      if (c > 1) step();
      if (c == 5) begin
        start = 1'b1;
        a     = 8'h07;
        b     = 8'h07;
      end else begin
        start = 1'b0;
      end
      checks++;
      if (busy !== 1'b1 || done !== 1'b0) begin
        errors++;
        $display("FAIL ignore_busy cyc=%0d: busy=%b done=%b, required 1 0", c, busy, done);
      end
    end
    start = 1'b0;
    step();
    model_prod = 16'h000C;
    checks++;
    if (done !== 1'b1 || product !== 16'h000C) begin
      errors++;
      $display("FAIL ignore_result: done=%b product=%h, required 1 000c", done, product);
    end
    for (int i = 0; i < 20; i++) begin
      step();
      checks++;
      if (done !== 1'b0 || busy !== 1'b0 || product !== 16'h000C) begin
        errors++;
        $display("FAIL ignore_no_second cyc=%0d: done=%b busy=%b product=%h, required 0 0 000c",
                 i, done, busy, product);
      end
    end
  endtask

  task automatic test_reset_mid_op();
    start = 1'b1;
    a     = 8'h12;
    b     = 8'h34;
    step();
    start = 1'b0;
    for (int c = 2; c <= 7; c++) step();
    rstn = 1'b0;
    step();
    model_prod = 16'h0000;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || product !== 16'h0000) begin
      errors++;
      $display("FAIL midreset_state: busy=%b done=%b product=%h, required 0 0 0000", busy, done, product);
    end
    rstn = 1'b1;
    for (int i = 0; i < 20; i++) begin
      step();
      checks++;
      if (busy !== 1'b0 || done !== 1'b0) begin
        errors++;
        $display("FAIL midreset_quiet cyc=%0d: busy=%b done=%b, required 0 0", i, busy, done);
      end
    end
    mult_op(8'h02, 8'h03, "after_reset");
    checks++;
    if (product !== 16'h0006) begin
      errors++;
      $display("FAIL after_reset_value: product=%h, required 0006", product);
    end
  endtask

  task automatic test_back_to_back();
    int first_done;
    int second_done;
    first_done  = -1;
    second_done = -1;
    start = 1'b1;
    a     = 8'h10;
    b     = 8'h10;
    for (int c = 1; c <= 40 && second_done < 0; c++) begin
      step();
      if (done === 1'b1 && first_done < 0) begin
        first_done = c;
        checks++;
        if (product !== 16'h0100) begin
          errors++;
          $display("FAIL b2b_first: product=%h, required 0100", product);
        end
        a = 8'h05;
        b = 8'h06;
      end else if (done === 1'b1) begin
        second_done = c;
        checks++;
        if (product !== 16'h001E) begin
          errors++;
          $display("FAIL b2b_second: product=%h, required 001e", product);
        end
      end else if (first_done >= 0) begin
        start = 1'b0;
        checks++;
        if (product !== 16'h0100 || busy !== 1'b1) begin
          errors++;
          $display("FAIL b2b_between cyc=%0d: product=%h busy=%b, required 0100 1", c, product, busy);
        end
      end
    end
    start = 1'b0;
    checks++;
    if (first_done != 17 || second_done != 34) begin
      errors++;
      $display("FAIL b2b_timing: first_done=%0d second_done=%0d, required 17 34", first_done, second_done);
    end
    model_prod = 16'h001E;
    step();
    step();
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_basic();
    test_corners();
    test_random();
    test_ignore_busy_start();
    test_reset_mid_op();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
